lc3b_mem_port: RTL and testbench

Parametrised memory-access unit that replaces the fixed 16-bit MAR/MDR pair and the byte zero-extenders with one self-sequencing block. It takes a single load/store request from the control unit and runs the `mem_read`/`mem_write`/`mem_resp` handshake with memory. It handles word and byte lanes for any power-of-two data width, and returns zero- or sign-extended byte loads. An optional response timeout flags a hung memory.

---
 rtl/lc3b_mem_port.sv | 208 ++++++++++++++++++++
 tb/tb_lc3b_mem_port.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_port.sv
// Memory-access unit for the LC-3b datapath: accepts one load/store request, runs the
// mem_read/mem_write/mem_resp handshake, and formats byte lanes for any power-of-two width.
module lc3b_mem_port #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [WIDTH/8-1:0]    mem_byte_enable,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_resp,
    output logic [1:0]            dbg_state
);

    localparam int NB = WIDTH / 8;
    localparam int L  = $clog2(NB);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so nothing is queued while an access is in flight.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic                  byte_q, byte_d;
    logic                  signed_q, signed_d;
    logic [L-1:0]          lane_q, lane_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  timeout_hit;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic [NB-1:0]         be_onehot;
    logic [7:0]            sel_byte;
    logic [WIDTH-1:0]      fmt_rdata;

    always_comb begin
        addr_word         = req_addr;
        addr_word[L-1:0]  = '0;
        be_onehot         = '0;
        be_onehot[req_addr[L-1:0]] = 1'b1;
    end

    // Lane is taken from the registered request so late req_addr changes cannot disturb it.
    always_comb begin
        sel_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        if (!byte_q) begin
            fmt_rdata = mem_rdata;
        end else if (signed_q) begin
            fmt_rdata = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
        end else begin
            fmt_rdata = {{(WIDTH-8){1'b0}}, sel_byte};
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_timeout
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (accept) begin
                    cnt_d = '0;
                end else if (state_q == S_ACCESS) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign timeout_hit = (state_q == S_ACCESS) && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        byte_d      = byte_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept      = 1'b1;
                    state_d     = S_ACCESS;
                    mem_read_d  = ~req_write;
                    mem_write_d = req_write;
                    byte_d      = req_byte;
                    signed_d    = req_signed;
                    lane_d      = req_addr[L-1:0];
                    if (req_byte) begin
                        addr_d  = req_addr;
                        wdata_d = {NB{req_wdata[7:0]}};
                        be_d    = be_onehot;
                    end else begin
                        addr_d  = addr_word;
                        wdata_d = req_wdata;
                        be_d    = '1;
                    end
                end
            end
            S_ACCESS: begin
                // A response in the timeout cycle still counts as success.
                if (mem_resp) begin
                    state_d     = S_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b0;
                    if (mem_read_q) begin
                        rdata_d = fmt_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d     = S_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            byte_q      <= 1'b0;
            signed_q    <= 1'b0;
            lane_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            byte_q      <= byte_d;
            signed_q    <= signed_d;
            lane_q      <= lane_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign rsp_valid       = (state_q == S_DONE);
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_lc3b_mem_port.sv
// Directed bench for lc3b_mem_port: a 16-bit instance with TIMEOUT=4 and a 32-bit
// instance with the timeout disabled, driven from vector tables and short sequences.
module tb_lc3b_mem_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance, TIMEOUT=4
    logic        a_req_valid, a_req_ready, a_req_write, a_req_byte, a_req_signed;
    logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_address, a_mem_wdata, a_mem_rdata;
    logic        a_rsp_valid, a_rsp_err, a_mem_read, a_mem_write, a_mem_resp;
    logic [1:0]  a_mem_be, a_dbg_state;

    // 32-bit instance, timeout disabled
    logic        b_req_valid, b_req_ready, b_req_write, b_req_byte, b_req_signed;
    logic [15:0] b_req_addr, b_mem_address;
    logic [31:0] b_req_wdata, b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_rsp_valid, b_rsp_err, b_mem_read, b_mem_write, b_mem_resp;
    logic [3:0]  b_mem_be;
    logic [1:0]  b_dbg_state;

    lc3b_mem_port #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_byte(a_req_byte), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_address(a_mem_address), .mem_wdata(a_mem_wdata), .mem_byte_enable(a_mem_be),
        .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp), .dbg_state(a_dbg_state)
    );

    lc3b_mem_port #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(0)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_byte(b_req_byte), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_be),
        .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp), .dbg_state(b_dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic        byt;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_be;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    // One complete access on the 16-bit instance; called with the unit idle, #1 after an edge.
    task automatic run16(input string tag, input vec_t v);
        chk({tag, " ready"}, a_req_ready, 1'b1);
        a_req_valid  = 1'b1;
        a_req_write  = v.wr;
        a_req_byte   = v.byt;
        a_req_signed = v.sgn;
        a_req_addr   = v.addr;
        a_req_wdata  = v.wdata;
        step();
        a_req_valid = 1'b0;
        a_req_addr  = ~v.addr;
        a_req_wdata = ~v.wdata;
        chk({tag, " read"}, a_mem_read, !v.wr);
        chk({tag, " write"}, a_mem_write, v.wr);
        chk({tag, " addr"}, a_mem_address, v.exp_addr);
        if (v.wr) begin
            chk({tag, " wdata"}, a_mem_wdata, v.exp_wdata);
            chk({tag, " be"}, a_mem_be, v.exp_be);
        end
        for (int i = 0; i < v.delay; i++) begin
            chk({tag, " no early rsp"}, a_rsp_valid, 1'b0);
            step();
            chk({tag, " strobe held"}, a_mem_read | a_mem_write, 1'b1);
            chk({tag, " addr held"}, a_mem_address, v.exp_addr);
        end
        a_mem_rdata = v.rdata;
        a_mem_resp  = 1'b1;
        step();
        a_mem_resp  = 1'b0;
        a_mem_rdata = 16'hDEAD;
        chk({tag, " rsp_valid"}, a_rsp_valid, 1'b1);
        chk({tag, " rsp_err"}, a_rsp_err, 1'b0);
        chk({tag, " rsp_rdata"}, a_rsp_rdata, v.exp_rdata);
        chk({tag, " strobes low"}, {a_mem_read, a_mem_write}, 2'b00);
        chk({tag, " dbg done"}, a_dbg_state, 2'd2);
        step();
        chk({tag, " rsp pulse"}, a_rsp_valid, 1'b0);
        chk({tag, " ready again"}, a_req_ready, 1'b1);
    endtask

    task automatic run32_load(input string tag, input logic byt, input logic sgn,
                              input logic [15:0] addr, input logic [31:0] rdata,
                              input logic [15:0] exp_addr, input logic [31:0] exp_rdata);
        b_req_valid  = 1'b1;
        b_req_write  = 1'b0;
        b_req_byte   = byt;
        b_req_signed = sgn;
        b_req_addr   = addr;
        step();
        b_req_valid = 1'b0;
        chk({tag, " read"}, b_mem_read, 1'b1);
        chk({tag, " addr"}, b_mem_address, exp_addr);
        b_mem_rdata = rdata;
        b_mem_resp  = 1'b1;
        step();
        b_mem_resp  = 1'b0;
        b_mem_rdata = 32'h0;
        chk({tag, " rsp_valid"}, b_rsp_valid, 1'b1);
        chk({tag, " rsp_rdata"}, b_rsp_rdata, exp_rdata);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 wr    byte  sgn   addr      wdata     rdata    d  e_addr    e_wdata   be     e_rdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h3001, 16'h1234, 16'hBEEF, 2, 16'h3000, 16'h1234, 2'b11, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h80F0, 0, 16'h0001, 16'h0000, 2'b10, 16'hFF80};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h80F0, 1, 16'h0000, 16'h0000, 2'b01, 16'h00F0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h80F0, 3, 16'h0000, 16'h0000, 2'b01, 16'hFFF0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h80F0, 0, 16'h0001, 16'h0000, 2'b10, 16'h0080};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h4003, 16'hCAFE, 16'hFFFF, 1, 16'h4002, 16'hCAFE, 2'b11, 16'h0080};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h12A5, 16'hFFFF, 0, 16'h0011, 16'hA5A5, 2'b10, 16'h0080};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h003C, 16'hFFFF, 2, 16'h0010, 16'h3C3C, 2'b01, 16'h0080};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h7FFE, 16'h0000, 16'h8001, 0, 16'h7FFE, 16'h0000, 2'b11, 16'h8001};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h7F00, 1, 16'h0001, 16'h0000, 2'b10, 16'h007F};

        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_byte = 1'b0; a_req_signed = 1'b0;
        a_req_addr = 16'h0; a_req_wdata = 16'h0; a_mem_rdata = 16'h0; a_mem_resp = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_byte = 1'b0; b_req_signed = 1'b0;
        b_req_addr = 16'h0; b_req_wdata = 32'h0; b_mem_rdata = 32'h0; b_mem_resp = 1'b0;

        // Reset state
        step();
        step();
        chk("reset ready", a_req_ready, 1'b1);
        chk("reset rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 18'h0);
        chk("reset strobes", {a_mem_read, a_mem_write}, 2'b00);
        chk("reset mem bus", {a_mem_address, a_mem_wdata, a_mem_be}, 34'h0);
        chk("reset dbg", a_dbg_state, 2'd0);
        chk("reset32 bus", {b_mem_read, b_mem_write, b_mem_address, b_mem_wdata, b_mem_be}, 54'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run16($sformatf("vec%0d", i), vecs[i]);
        end

        // 32-bit byte store held for several cycles before the response
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_byte = 1'b1;
        b_req_addr = 16'h0102; b_req_wdata = 32'h000000A5;
        step();
        b_req_valid = 1'b0; b_req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            chk("stb32 write", {b_mem_write, b_mem_read}, 2'b10);
            chk("stb32 wdata", b_mem_wdata, 32'hA5A5A5A5);
            chk("stb32 be", b_mem_be, 4'b0100);
            chk("stb32 addr", b_mem_address, 16'h0102);
            chk("stb32 no rsp", b_rsp_valid, 1'b0);
            step();
        end
        b_mem_resp = 1'b1; b_mem_rdata = 32'hFFFFFFFF;
        step();
        b_mem_resp = 1'b0;
        chk("stb32 rsp", {b_rsp_valid, b_rsp_err, b_mem_write}, 3'b100);
        chk("stb32 rdata kept", b_rsp_rdata, 32'h0);
        step();
        chk("stb32 ready", b_req_ready, 1'b1);
        run32_load("ld32 word", 1'b0, 1'b0, 16'h0107, 32'h12345678, 16'h0104, 32'h12345678);
        run32_load("ld32 b3s", 1'b1, 1'b1, 16'h0107, 32'h80FFFFFF, 16'h0107, 32'hFFFFFF80);
        run32_load("ld32 b2u", 1'b1, 1'b0, 16'h0106, 32'h00C30000, 16'h0106, 32'h000000C3);

        // Timeout with no response: strobe high exactly 4 cycles
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_byte = 1'b0; a_req_addr = 16'h0200;
        step();
        a_req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("tmo read c%0d", i), a_mem_read, 1'b1);
            chk($sformatf("tmo no rsp c%0d", i), a_rsp_valid, 1'b0);
            step();
        end
        chk("tmo rsp_valid", a_rsp_valid, 1'b1);
        chk("tmo rsp_err", a_rsp_err, 1'b1);
        chk("tmo rdata", a_rsp_rdata, 16'h0);
        chk("tmo read low", a_mem_read, 1'b0);
        step();
        chk("tmo ready", {a_req_ready, a_rsp_valid}, 2'b10);

        // Response in the timeout cycle wins
        a_req_valid = 1'b1; a_req_addr = 16'h0202;
        step();
        a_req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("tmo2 read c%0d", i), a_mem_read, 1'b1);
            step();
        end
        chk("tmo2 read c4", a_mem_read, 1'b1);
        a_mem_resp = 1'b1; a_mem_rdata = 16'h5A5A;
        step();
        a_mem_resp = 1'b0;
        chk("tmo2 rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
        chk("tmo2 rdata", a_rsp_rdata, 16'h5A5A);
        step();

        // Asynchronous reset in the second ACCESS cycle
        a_req_valid = 1'b1; a_req_addr = 16'h0300;
        step();
        a_req_valid = 1'b0;
        step();
        chk("rst pre read", a_mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst strobe drop", {a_mem_read, a_mem_write}, 2'b00);
        chk("rst outputs", {a_rsp_valid, a_rsp_err, a_rsp_rdata, a_mem_address, a_mem_wdata, a_mem_be}, 52'h0);
        chk("rst ready", a_req_ready, 1'b1);
        step();
        chk("rst no rsp", a_rsp_valid, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst no rsp after", a_rsp_valid, 1'b0);
        run16("post rst", '{1'b0, 1'b0, 1'b0, 16'h1000, 16'h0, 16'h1357, 0, 16'h1000, 16'h0, 2'b11, 16'h1357});

        // Protocol noise: stray mem_resp in IDLE, req_valid held through ACCESS/DONE
        a_mem_resp = 1'b1;
        step();
        a_mem_resp = 1'b0;
        chk("noise idle resp", {a_rsp_valid, a_mem_read, a_req_ready}, 3'b001);
        step();
        chk("noise idle resp2", a_rsp_valid, 1'b0);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_byte = 1'b0; a_req_addr = 16'h2000;
        step();
        a_req_addr = 16'h3000;
        chk("noise read", a_mem_read, 1'b1);
        step();
        chk("noise addr kept", a_mem_address, 16'h2000);
        a_mem_resp = 1'b1; a_mem_rdata = 16'h2468;
        step();
        a_mem_resp = 1'b0;
        chk("noise rsp", a_rsp_valid, 1'b1);
        chk("noise rdata", a_rsp_rdata, 16'h2468);
        step();
        a_req_valid = 1'b0;
        chk("noise idle", {a_req_ready, a_rsp_valid, a_mem_read}, 3'b100);
        step();
        chk("noise no restart", {a_mem_read, a_rsp_valid, a_req_ready}, 3'b001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
